// File: rtl/asym_ram_fifo_ctrl_pkg.sv
// Shared constants for the byte-in / word-out asymmetric RAM FIFO.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package asym_ram_fifo_ctrl_pkg;

  // Bytes packed per RAM word
  localparam int RATIO = 4;

  // Read-sequencer state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ADDR  = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_VALID = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    ADDR  = ST_ADDR,
    DATA  = ST_DATA,
    VALID = ST_VALID
  } rdState_t;

endpackage

// File: rtl/asym_ram_store.sv
// Asymmetric storage: byte-wide synchronous write, word-wide two-register read.
// Latency: write visible next cycle; read data appears two enabled clocks after address.
// Backpressure: none; the controller sequences rdEn/outEn and never overwrites live words.
module asym_ram_store
  import asym_ram_fifo_ctrl_pkg::*;
#(
  parameter int WIDTHA     = 8,
  parameter int SIZEA      = 256,
  parameter int ADDRWIDTHA = 8,
  parameter int WIDTHB     = 32,
  parameter int ADDRWIDTHB = 6
) (
  input  logic                  clk,
  input  logic                  wrEn,
  input  logic [ADDRWIDTHA-1:0] wrAddr,
  input  logic [WIDTHA-1:0]     wrData,
  input  logic                  rdEn,
  input  logic [ADDRWIDTHB-1:0] rdAddr,
  input  logic                  outEn,
  output logic [WIDTHB-1:0]     rdData
);

  localparam int LANEW = ADDRWIDTHA - ADDRWIDTHB;

  logic [WIDTHA-1:0] mem [SIZEA];
  logic [WIDTHB-1:0] readReg;

  // Byte write port
  always_ff @(posedge clk) begin
    if (wrEn) mem[wrAddr] <= wrData;
  end

  // Word read register: lane k holds byte address {rdAddr, k} (little-endian)
  always_ff @(posedge clk) begin
    if (rdEn) begin
      for (int k = 0; k < RATIO; k++) begin
        readReg[k*WIDTHA +: WIDTHA] <= mem[{rdAddr, LANEW'(k)}];
      end
    end
  end

  // Output register, only loaded when the sequencer enables it so dout holds
  always_ff @(posedge clk) begin
    if (outEn) rdData <= readReg;
  end

endmodule

// File: rtl/asym_ram_fifo_ctrl.sv
// Byte-in / word-out FIFO controller: packs 4 bytes per word over an asymmetric RAM.
// Latency: 4th byte accepted at edge E0 -> dout_valid after E3; 1 word per 3 cycles sustained.
// Backpressure: din_ready low when 256 bytes held; dout held stable until dout_ready.
module asym_ram_fifo_ctrl
  import asym_ram_fifo_ctrl_pkg::*;
#(
  parameter int WIDTHA     = 8,
  parameter int SIZEA      = 256,
  parameter int ADDRWIDTHA = 8,
  parameter int WIDTHB     = 32,
  parameter int SIZEB      = 64,
  parameter int ADDRWIDTHB = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTHA-1:0]     din,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic [WIDTHB-1:0]     dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic [ADDRWIDTHA:0]   fill_bytes,
  output logic [ADDRWIDTHB:0]   words_avail
);

  localparam int LANEW = ADDRWIDTHA - ADDRWIDTHB;

  if (SIZEB * RATIO != SIZEA || WIDTHB != RATIO * WIDTHA || LANEW != $clog2(RATIO)) begin : gSizeCheck
    $error("asym_ram_fifo_ctrl: inconsistent word/byte geometry");
  end

  // Pointers carry one extra wrap bit above the RAM address
  logic [ADDRWIDTHA:0] wrPtr;
  logic [ADDRWIDTHB:0] rdPtr;
  rdState_t            state, stateNxt;
  logic                wrFire, rdFire, ramRdEn, ramOutEn;

  assign fill_bytes  = wrPtr - {rdPtr, {LANEW{1'b0}}};
  assign words_avail = wrPtr[ADDRWIDTHA:LANEW] - rdPtr;
  assign din_ready   = (fill_bytes != SIZEA[ADDRWIDTHA:0]);
  assign wrFire      = din_valid && din_ready;
  assign dout_valid  = (state == VALID);
  // rd_ptr moves only here, so the word being read stays counted and is never overwritten
  assign rdFire      = dout_valid && dout_ready;

  // Pointer update; both may move in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (wrFire) wrPtr <= wrPtr + (ADDRWIDTHA+1)'(1);
      if (rdFire) rdPtr <= rdPtr + (ADDRWIDTHB+1)'(1);
    end
  end

  // Read sequencer state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNxt;
  end

  // Read sequencer next state and RAM enables
  always_comb begin
    stateNxt = state;
    ramRdEn  = 1'b0;
    ramOutEn = 1'b0;
    case (state)
      IDLE:  if (words_avail != '0) stateNxt = ADDR;
      ADDR:  begin
        ramRdEn  = 1'b1;
        stateNxt = DATA;
      end
      DATA:  begin
        ramOutEn = 1'b1;
        stateNxt = VALID;
      end
      VALID: begin
        // words_avail still includes the word handed over now, so "one left" means none after
        if (dout_ready) stateNxt = (words_avail != (ADDRWIDTHB+1)'(1)) ? ADDR : IDLE;
      end
      default: stateNxt = IDLE;
    endcase
  end

  asym_ram_store #(
    .WIDTHA     (WIDTHA),
    .SIZEA      (SIZEA),
    .ADDRWIDTHA (ADDRWIDTHA),
    .WIDTHB     (WIDTHB),
    .ADDRWIDTHB (ADDRWIDTHB)
  ) uStore (
    .clk    (clk),
    .wrEn   (wrFire),
    .wrAddr (wrPtr[ADDRWIDTHA-1:0]),
    .wrData (din),
    .rdEn   (ramRdEn),
    .rdAddr (rdPtr[ADDRWIDTHB-1:0]),
    .outEn  (ramOutEn),
    .rdData (dout)
  );

endmodule
